merge_parallel_n: RTL

N-channel parallel merge for valid/ready streams. Collects one beat from each of `NUM_CH` independent input channels, in any order and at any time, and emits one concatenated output beat once all channels have delivered. Each channel has a one-entry holding slot and the output is registered, so sustained throughput is one merged beat per cycle. Sits in the bus layer between independent producers and any consumer that needs aligned multi-field words.

---
 rtl/merge_parallel_n.sv | 108 ++++++++++
 1 files changed

// File: rtl/merge_parallel_n.sv
// N-channel parallel merge: one holding slot per channel, registered output beat.
// Optional handshake counter port merge_cnt is enabled by MERGE_PARALLEL_N_CNT_EN.
module merge_parallel_n #(
  parameter int NUM_CH   = 2,
  parameter int CH_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [NUM_CH-1:0]          s_valid,
  output logic [NUM_CH-1:0]          s_ready,
  input  logic [NUM_CH*CH_WIDTH-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_CH*CH_WIDTH-1:0] m_data
`ifdef MERGE_PARALLEL_N_CNT_EN
  ,
  output logic [15:0]                merge_cnt
`endif
);

  localparam int DW = NUM_CH * CH_WIDTH;

  logic [NUM_CH-1:0] full_r;
  logic [NUM_CH-1:0] full_nxt;
  logic [DW-1:0]     slot_r;
  logic [DW-1:0]     slot_nxt;
  logic              m_valid_r;
  logic              m_valid_nxt;
  logic [DW-1:0]     m_data_r;
  logic [DW-1:0]     m_data_nxt;
  logic              out_free_s;
  logic              fire_s;
  logic [NUM_CH-1:0] accept_s;

  // Merge condition and per-channel handshake; a slot reopens in the cycle it drains.
  always_comb begin
    out_free_s = ~m_valid_r | m_ready;
    fire_s     = (&full_r) & out_free_s;
    s_ready    = ~full_r | {NUM_CH{fire_s}};
    accept_s   = s_valid & s_ready;
  end

  // Slot next state: a same-edge accept wins over the drain caused by fire.
  always_comb begin
    full_nxt = full_r;
    slot_nxt = slot_r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s[i]) begin
        full_nxt[i]                      = 1'b1;
        slot_nxt[i*CH_WIDTH +: CH_WIDTH] = s_data[i*CH_WIDTH +: CH_WIDTH];
      end else if (fire_s) begin
        full_nxt[i] = 1'b0;
      end else begin
        full_nxt[i] = full_r[i];
      end
    end
  end

  // Output stage next state; m_data only changes on fire, so it holds under stall.
  always_comb begin
    m_valid_nxt = m_valid_r;
    m_data_nxt  = m_data_r;
    if (fire_s) begin
      m_valid_nxt = 1'b1;
      m_data_nxt  = slot_r;
    end else if (m_ready) begin
      m_valid_nxt = 1'b0;
    end else begin
      m_valid_nxt = m_valid_r;
    end
  end

  // State registers; reset discards any partially collected beat.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      full_r    <= {NUM_CH{1'b0}};
      slot_r    <= {DW{1'b0}};
      m_valid_r <= 1'b0;
      m_data_r  <= {DW{1'b0}};
    end else begin
      full_r    <= full_nxt;
      slot_r    <= slot_nxt;
      m_valid_r <= m_valid_nxt;
      m_data_r  <= m_data_nxt;
    end
  end

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;

`ifdef MERGE_PARALLEL_N_CNT_EN
  logic [15:0] cnt_r;

  // Output handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_r <= 16'd0;
    end else if (m_valid_r & m_ready) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign merge_cnt = cnt_r;
`endif

endmodule
